rom_sample_fifo: RTL and testbench

Capture buffer directly downstream of the waveform ROM. On every rising `clk` edge where `wr_en` is high it stores the ROM's current sample (`data_out`/`addr_out`, which change on the falling edge and are stable at the rising edge) into a circular FIFO. Each entry is tagged with its table code (top two address bits) and a discontinuity flag. A valid/ready read port drains the FIFO toward the DAC/serial consumer. Overflow is counted as dropped samples, never as corrupted ones.

---
 rtl/rom_pkg.sv | 34 +++
 rtl/rom_sample_fifo_if.sv | 32 +++
 rtl/sample_fifo_mem.sv | 32 +++
 rtl/rom_sample_fifo.sv | 139 +++++++++++++
 tb/tb_rom_sample_fifo.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/rom_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_pkg
// Description : Shared waveform-ROM definitions: table codes, address split
//               and the packed layout of one captured sample.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_pkg;

    localparam int ROM_DATA_WIDTH   = 8;
    localparam int ROM_ADDR_WIDTH   = 10;
    localparam int TBL_CODE_WIDTH   = 2;
    localparam int TBL_OFFSET_WIDTH = ROM_ADDR_WIDTH - TBL_CODE_WIDTH;

    typedef enum logic [TBL_CODE_WIDTH-1:0] {
        TBL_SIN  = 2'b00,
        TBL_SIN1 = 2'b01,
        TBL_GAUS = 2'b10,
        TBL_EXP  = 2'b11
    } tbl_code_e;

    typedef struct packed {
        logic                      disc;
        logic [ROM_ADDR_WIDTH-1:0] addr;
        logic [ROM_DATA_WIDTH-1:0] data;
    } rom_entry_t;

    // First ROM address of a table.
    function automatic logic [ROM_ADDR_WIDTH-1:0] tbl_base(input tbl_code_e code);
        return {code, {TBL_OFFSET_WIDTH{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_sample_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_sample_fifo_if
// Description : Capture-side write strobe/sample and valid/ready read port of
//               the ROM sample FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_sample_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  rd_ready;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [1:0]            rd_table;
    logic                  rd_disc;

    modport master (
        output wr_en, wr_data, wr_addr, rd_ready,
        input  rd_valid, rd_data, rd_addr, rd_table, rd_disc
    );

    modport slave (
        input  wr_en, wr_data, wr_addr, rd_ready,
        output rd_valid, rd_data, rd_addr, rd_table, rd_disc
    );
endinterface
`default_nettype wire

// File: rtl/sample_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo_mem
// Description : Register array, one synchronous write port and one
//               combinational read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo_mem #(
    parameter int WIDTH      = 19,
    parameter int DEPTH_LOG2 = 4
) (
    input  wire logic                  clk,
    input  wire logic                  we,
    input  wire logic [DEPTH_LOG2-1:0] waddr,
    input  wire logic [WIDTH-1:0]      wdata,
    input  wire logic [DEPTH_LOG2-1:0] raddr,
    output      logic [WIDTH-1:0]      rdata
);
    localparam int c_DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/rom_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rom_sample_fifo
// Description : Circular capture FIFO behind the waveform ROM with per-entry
//               discontinuity tagging, show-ahead read and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_sample_fifo
    import rom_pkg::*;
#(
    parameter int DATA_WIDTH = ROM_DATA_WIDTH,
    parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
    parameter int DEPTH_LOG2 = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            flush,
    input  wire logic            clear_ovf,
    rom_sample_fifo_if.slave     bus,
    output      logic [DEPTH_LOG2:0] count,
    output      logic            full,
    output      logic            empty,
    output      logic            overflow
);
    localparam int                     c_DEPTH    = 2 ** DEPTH_LOG2;
    localparam int                     c_OFF_W    = ADDR_WIDTH - 2;
    localparam int                     c_ENTRY_W  = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [DEPTH_LOG2-1:0]  c_PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]    c_CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]    c_CNT_FULL = (DEPTH_LOG2+1)'(c_DEPTH);
    localparam logic [c_OFF_W-1:0]     c_OFF_ONE  = c_OFF_W'(1);

    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_overflow;
    logic                  r_hist_valid;
    logic [ADDR_WIDTH-1:0] r_prev_addr;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_disc;
    logic [ADDR_WIDTH-1:0] w_expected;
    logic [DEPTH_LOG2:0]   w_count_nxt;
    logic [c_ENTRY_W-1:0]  w_wr_entry;
    logic [c_ENTRY_W-1:0]  w_rd_entry;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    // Flush masks the write side entirely, so a flushed sample neither stores
    // nor counts as a drop.
    assign w_pop  = !r_empty && bus.rd_ready;
    assign w_push = bus.wr_en && !flush && (!r_full || w_pop);
    assign w_drop = bus.wr_en && !flush && r_full && !w_pop;

    // Successor stays inside the previous table; the offset wraps like the ROM.
    assign w_expected = {r_prev_addr[ADDR_WIDTH-1 -: 2], r_prev_addr[c_OFF_W-1:0] + c_OFF_ONE};
    assign w_disc     = !r_hist_valid || (bus.wr_addr != w_expected);
    assign w_wr_entry = {w_disc, bus.wr_addr, bus.wr_data};

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_hist_valid <= 1'b0;
            r_prev_addr  <= '0;
        end else if (flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_hist_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + c_PTR_ONE;
                r_prev_addr  <= bus.wr_addr;
                r_hist_valid <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_CNT_FULL);
            r_empty <= (w_count_nxt == '0);
        end
    end

    // A drop in the same cycle as clear_ovf keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    sample_fifo_mem #(
        .WIDTH      (c_ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (w_wr_entry),
        .raddr (r_rd_ptr),
        .rdata (w_rd_entry)
    );

    assign w_rd_addr    = r_empty ? '0 : w_rd_entry[DATA_WIDTH +: ADDR_WIDTH];
    assign bus.rd_valid = !r_empty;
    assign bus.rd_data  = r_empty ? '0 : w_rd_entry[DATA_WIDTH-1:0];
    assign bus.rd_addr  = w_rd_addr;
    assign bus.rd_table = w_rd_addr[ADDR_WIDTH-1 -: 2];
    assign bus.rd_disc  = r_empty ? 1'b0 : w_rd_entry[c_ENTRY_W-1];

    assign count    = r_count;
    assign full     = r_full;
    assign empty    = r_empty;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rom_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_sample_fifo
// Description : Directed self-checking bench for rom_sample_fifo with a
//               queue scoreboard of expected FIFO entries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_sample_fifo;
    import rom_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       clear_ovf;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    int vectors;
    int miscompares;

    rom_entry_t q[$];
    logic       m_hist;
    logic [9:0] m_prev;
    logic       m_ovf;

    rom_sample_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) bus ();

    rom_sample_fifo #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (10),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .clear_ovf (clear_ovf),
        .bus       (bus.slave),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus; scoreboard pops are checked before the edge,
    // occupancy/status after it.
    task automatic cyc(input logic wr, input logic [9:0] a, input logic [7:0] d,
                       input logic rdy, input logic fl = 1'b0, input logic clr = 1'b0);
        rom_entry_t e;
        logic       pop;
        logic       push;
        logic       drop;
        bus.wr_en    = wr;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.rd_ready = rdy;
        flush        = fl;
        clear_ovf    = clr;
        drop         = 1'b0;
        if (fl) begin
            q.delete();
            m_hist = 1'b0;
        end else begin
            pop = (q.size() != 0) && rdy;
            if (pop) begin
                e = q.pop_front();
                chk("pop_addr",  32'(bus.rd_addr),  32'(e.addr));
                chk("pop_data",  32'(bus.rd_data),  32'(e.data));
                chk("pop_disc",  32'(bus.rd_disc),  32'(e.disc));
                chk("pop_table", 32'(bus.rd_table), 32'(e.addr[9:8]));
            end
            push = wr && (q.size() < 16);
            if (push) begin
                e.disc = !m_hist || (a != {m_prev[9:8], m_prev[7:0] + 8'd1});
                e.addr = a;
                e.data = d;
                q.push_back(e);
                m_hist = 1'b1;
                m_prev = a;
            end else if (wr) begin
                drop = 1'b1;
            end
        end
        if (drop)     m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        chk("count",    32'(count),        32'(q.size()));
        chk("rd_valid", 32'(bus.rd_valid), 32'(q.size() != 0));
        chk("overflow", 32'(overflow),     32'(m_ovf));
    endtask

    initial begin
        logic [7:0] ramp [4];
        vectors      = 0;
        miscompares  = 0;
        m_hist       = 1'b0;
        m_prev       = '0;
        m_ovf        = 1'b0;
        ramp[0] = 8'h80; ramp[1] = 8'h8C; ramp[2] = 8'h98; ramp[3] = 8'hA5;
        rst_n        = 1'b0;
        flush        = 1'b0;
        clear_ovf    = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",    32'(count),        0);
        chk("rst_empty",    32'(empty),        1);
        chk("rst_full",     32'(full),         0);
        chk("rst_valid",    32'(bus.rd_valid), 0);
        chk("rst_overflow", 32'(overflow),     0);
        chk("rst_data",     32'(bus.rd_data),  0);
        chk("rst_disc",     32'(bus.rd_disc),  0);
        rst_n = 1'b1;

        // Four contiguous samples from table 1.
        for (int i = 0; i < 4; i++) cyc(1'b1, 10'h100 + 10'(i), ramp[i], 1'b0);
        chk("ramp_count", 32'(count),        4);
        chk("ramp_addr",  32'(bus.rd_addr),  32'h100);
        chk("ramp_data",  32'(bus.rd_data),  32'h80);
        chk("ramp_table", 32'(bus.rd_table), 1);
        chk("ramp_disc",  32'(bus.rd_disc),  1);
        cyc(1'b0, '0, '0, 1'b1);
        chk("ramp_disc1", 32'(bus.rd_disc), 0);
        repeat (3) cyc(1'b0, '0, '0, 1'b1);
        chk("drain_empty", 32'(empty),       1);
        chk("drain_zero",  32'(bus.rd_addr), 0);

        // Overfill: 16 accepted, 4 dropped.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 10'h200 + 10'(i), 8'(i), 1'b0);
            if (i == 15) begin
                chk("full16",  32'(full),  1);
                chk("count16", 32'(count), 16);
            end
        end
        chk("ovf_set",  32'(overflow), 1);
        chk("ovf_full", 32'(full),     1);

        // Simultaneous push and pop at full.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 10'h210 + 10'(i), 8'h40 + 8'(i), 1'b1);
            chk("rw_full_count", 32'(count), 16);
        end
        repeat (16) cyc(1'b0, '0, '0, 1'b1);
        chk("rw_drained", 32'(empty), 1);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 0);

        // Offset wrap inside a table, then a table change.
        cyc(1'b1, 10'h1FF, 8'h11, 1'b0);
        cyc(1'b1, 10'h100, 8'h22, 1'b0);
        cyc(1'b1, 10'h300, 8'h33, 1'b0);
        chk("wrap_head_disc", 32'(bus.rd_disc), 1);
        cyc(1'b0, '0, '0, 1'b1);
        chk("wrap_disc", 32'(bus.rd_disc), 0);
        cyc(1'b0, '0, '0, 1'b1);
        chk("tbl3_table", 32'(bus.rd_table), 3);
        chk("tbl3_disc",  32'(bus.rd_disc),  1);
        cyc(1'b0, '0, '0, 1'b1);

        // Flush at count 7 with a concurrent write.
        for (int i = 0; i < 7; i++) cyc(1'b1, 10'h040 + 10'(i), 8'h60 + 8'(i), 1'b0);
        chk("pre_flush_count", 32'(count), 7);
        cyc(1'b1, 10'h047, 8'h67, 1'b0, 1'b1);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_count", 32'(count), 0);
        cyc(1'b1, 10'h048, 8'h68, 1'b0);
        chk("post_flush_disc", 32'(bus.rd_disc), 1);
        chk("post_flush_addr", 32'(bus.rd_addr), 32'h048);
        cyc(1'b0, '0, '0, 1'b1);

        // Asynchronous reset mid-cycle at count 9.
        for (int i = 0; i < 9; i++) cyc(1'b1, 10'h380 + 10'(i), 8'(i), 1'b0);
        chk("pre_rst_count", 32'(count), 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count),        0);
        chk("arst_empty", 32'(empty),        1);
        chk("arst_valid", 32'(bus.rd_valid), 0);
        chk("arst_addr",  32'(bus.rd_addr),  0);
        chk("arst_data",  32'(bus.rd_data),  0);
        q.delete();
        m_hist = 1'b0;
        m_ovf  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 10'h385, 8'h99, 1'b0);
        chk("after_rst_disc", 32'(bus.rd_disc), 1);
        cyc(1'b0, '0, '0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
